morph3x3_cfg: RTL and testbench

Parametrised, run-time configurable 3×3 binary morphology stage for the camera image-filter chain. It replaces the fixed erosion-then-dilation pairing with one block that supports several operations: erode, dilate, or bypass, selected per frame. The line width and data width are set by parameters, and window pixels outside the frame are handled explicitly. Instances cascade directly, post_* to pre_*, to build open/close chains of any depth.

---
 rtl/morph3x3_cfg.sv | 202 ++++++++++++++++++++
 tb/tb_morph3x3_cfg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/morph3x3_cfg.sv
// rtl/morph3x3_cfg.sv - run-time configurable 3x3 binary erode/dilate/bypass stage
module morph3x3_cfg #(
    parameter int IMG_W  = 640,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_vs,
    input  logic              pre_hs,
    input  logic              pre_clken,
    input  logic              pre_imgbit,
    input  logic [DATA_W-1:0] pre_imgdata,
    input  logic [1:0]        cfg_mode,
    output logic              post_vs,
    output logic              post_hs,
    output logic              post_clken,
    output logic              post_imgbit,
    output logic [DATA_W-1:0] post_imgdata,
    output logic [1:0]        frame_mode,
    output logic              line_ovf
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] ROW_MAX = '1;
    localparam logic [CNT_W:0]   WIN_LO  = (CNT_W+1)'(2);
    localparam logic [CNT_W:0]   WIN_HI  = (CNT_W+1)'(IMG_W + 2);

    logic vs_d, hs_d, vs_rise, hs_fall;
    logic [CNT_W-1:0] col, row;
    logic col_in;
    logic [AW-1:0] addr;
    logic is_erode, is_dilate, ident;

    logic lb0 [IMG_W];
    logic lb1 [IMG_W];

    logic s1_vs, s1_hs, s1_clken, s1_bit, s1_lb0, s1_lb1;
    logic [DATA_W-1:0] s1_data;
    logic [CNT_W-1:0] s1_col, s1_row;

    logic [2:0] win_top, win_mid, win_bot;
    logic [2:0] nxt_top, nxt_mid, nxt_bot;
    logic [2:0] m_top, m_mid, m_bot;
    logic [2:0] col_ok;
    logic [CNT_W:0] pos;
    logic row_ok_mid, row_ok_top;

    logic s2_vs, s2_hs, s2_clken, s2_bit;
    logic [DATA_W-1:0] s2_data;
    logic [8:0] s2_win;
    logic result;

    assign vs_rise   = pre_vs & ~vs_d;
    assign hs_fall   = hs_d & ~pre_hs;
    assign col_in    = col < COL_MAX;
    assign addr      = col_in ? col[AW-1:0] : '0;
    assign is_erode  = frame_mode == 2'b01;
    assign is_dilate = frame_mode == 2'b10;
    assign ident     = is_erode;

    // Sync edge detection, column/row counters, per-frame mode latch and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b0;
            hs_d       <= 1'b0;
            col        <= '0;
            row        <= '0;
            frame_mode <= 2'b00;
            line_ovf   <= 1'b0;
        end else begin
            vs_d <= pre_vs;
            hs_d <= pre_hs;
            if (hs_fall)
                col <= '0;
            else if (pre_clken && col_in)
                col <= col + 1'b1;
            if (vs_rise)
                row <= '0;
            else if (hs_fall && row != ROW_MAX)
                row <= row + 1'b1;
            if (vs_rise)
                frame_mode <= cfg_mode;
            if (vs_rise)
                line_ovf <= 1'b0;
            else if (pre_clken && col == COL_MAX)
                line_ovf <= 1'b1;
        end
    end

    // Line buffers: lb0 takes the new pixel, lb1 takes the old lb0 bit (read-before-write)
    always_ff @(posedge clk) begin
        if (pre_clken && col_in) begin
            lb0[addr] <= pre_imgbit;
            lb1[addr] <= lb0[addr];
        end
    end

    // Stage 1: register the inputs, the line-buffer read and the counter position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vs    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_clken <= 1'b0;
            s1_bit   <= 1'b0;
            s1_data  <= '0;
            s1_lb0   <= 1'b0;
            s1_lb1   <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_vs    <= pre_vs;
            s1_hs    <= pre_hs;
            s1_clken <= pre_clken;
            s1_bit   <= pre_imgbit;
            s1_data  <= pre_imgdata;
            if (pre_clken) begin
                s1_lb0 <= lb0[addr];
                s1_lb1 <= lb1[addr];
            end
            s1_col   <= col;
            s1_row   <= row;
        end
    end

    // Shifted window and its edge mask; bit j holds column c-2+j, out-of-frame cells take the identity
    always_comb begin
        nxt_top    = {s1_lb1, win_top[2:1]};
        nxt_mid    = {s1_lb0, win_mid[2:1]};
        nxt_bot    = {s1_bit, win_bot[2:1]};
        row_ok_mid = s1_row != '0;
        row_ok_top = s1_row > CNT_W'(1);
        pos        = '0;
        col_ok     = '0;
        m_top      = '0;
        m_mid      = '0;
        m_bot      = '0;
        for (int j = 0; j < 3; j++) begin
            pos       = {1'b0, s1_col} + (CNT_W+1)'(j);
            col_ok[j] = (pos >= WIN_LO) && (pos < WIN_HI);
            m_top[j]  = (col_ok[j] && row_ok_top) ? nxt_top[j] : ident;
            m_mid[j]  = (col_ok[j] && row_ok_mid) ? nxt_mid[j] : ident;
            m_bot[j]  = col_ok[j] ? nxt_bot[j] : ident;
        end
    end

    // Stage 2: raw window shifts on qualified pixels only; masked copy and syncs advance every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_top  <= '0;
            win_mid  <= '0;
            win_bot  <= '0;
            s2_win   <= '0;
            s2_vs    <= 1'b0;
            s2_hs    <= 1'b0;
            s2_clken <= 1'b0;
            s2_bit   <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (s1_clken) begin
                win_top <= nxt_top;
                win_mid <= nxt_mid;
                win_bot <= nxt_bot;
            end
            s2_win   <= {m_top, m_mid, m_bot};
            s2_vs    <= s1_vs;
            s2_hs    <= s1_hs;
            s2_clken <= s1_clken;
            s2_bit   <= s1_bit;
            s2_data  <= s1_data;
        end
    end

    // Reduce the masked window: AND for erode, OR otherwise
    always_comb begin
        result = is_erode ? (&s2_win) : (|s2_win);
    end

    // Stage 3: select morphology or bypass and register the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vs      <= 1'b0;
            post_hs      <= 1'b0;
            post_clken   <= 1'b0;
            post_imgbit  <= 1'b0;
            post_imgdata <= '0;
        end else begin
            post_vs    <= s2_vs;
            post_hs    <= s2_hs;
            post_clken <= s2_clken;
            if (is_erode || is_dilate) begin
                post_imgbit  <= result;
                post_imgdata <= {DATA_W{result}};
            end else begin
                post_imgbit  <= s2_bit;
                post_imgdata <= s2_data;
            end
        end
    end

endmodule

// File: tb/tb_morph3x3_cfg.sv
// tb/tb_morph3x3_cfg.sv - scoreboard bench for morph3x3_cfg
module tb_morph3x3_cfg;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pre_vs, pre_hs, pre_clken, pre_imgbit;
    logic [15:0] pre_imgdata;
    logic [1:0]  cfg_mode;
    logic        post_vs, post_hs, post_clken, post_imgbit;
    logic [15:0] post_imgdata;
    logic [1:0]  frame_mode;
    logic        line_ovf;

    typedef struct {
        logic        b;
        logic [15:0] d;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [1:0]  exp_mode;
    logic        img [16][16];
    logic [15:0] dat [16][16];

    morph3x3_cfg #(.IMG_W(W), .DATA_W(16), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pre_vs       (pre_vs),
        .pre_hs       (pre_hs),
        .pre_clken    (pre_clken),
        .pre_imgbit   (pre_imgbit),
        .pre_imgdata  (pre_imgdata),
        .cfg_mode     (cfg_mode),
        .post_vs      (post_vs),
        .post_hs      (post_hs),
        .post_clken   (post_clken),
        .post_imgbit  (post_imgbit),
        .post_imgdata (post_imgdata),
        .frame_mode   (frame_mode),
        .line_ovf     (line_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic gold(input int r, input int c, input logic [1:0] m);
        logic id, acc, v;
        int   rr, cc;
        id  = (m == 2'b01);
        acc = id;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r - 2 + dr;
                cc = c - 2 + dc;
                v  = (rr >= 0 && cc >= 0 && cc < W) ? img[rr][cc] : id;
                acc = (m == 2'b01) ? (acc & v) : (acc | v);
            end
        end
        return acc;
    endfunction

    task automatic fill_img(input int kind);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (kind)
                    1:       img[r][c] = 1'b1;
                    2:       img[r][c] = 1'b0;
                    3:       img[r][c] = ($urandom_range(0, 9) != 0);
                    default: img[r][c] = 1'($urandom_range(0, 1));
                endcase
                dat[r][c] = 16'($urandom);
            end
        end
        if (kind == 1) img[4][4] = 1'b0;
        if (kind == 2) img[4][4] = 1'b1;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check("rst_mid_vs",    post_vs,      0);
        check("rst_mid_hs",    post_hs,      0);
        check("rst_mid_clken", post_clken,   0);
        check("rst_mid_bit",   post_imgbit,  0);
        check("rst_mid_data",  post_imgdata, 0);
        check("rst_mid_mode",  frame_mode,   0);
        check("rst_mid_ovf",   line_ovf,     0);
        sb.delete();
        pre_vs = 0; pre_hs = 0; pre_clken = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input logic [1:0] mode, input int rows, input int cols,
                             input bit gapped, input int sw_row, input logic [1:0] sw_mode,
                             input int rst_row, input int rst_col);
        exp_t e;
        logic v;
        @(negedge clk);
        cfg_mode = mode;
        pre_vs   = 1'b1;
        exp_mode = mode;
        repeat (2) @(negedge clk);
        for (int r = 0; r < rows; r++) begin
            if (r == sw_row) cfg_mode = sw_mode;
            for (int c = 0; c < cols; c++) begin
                if (gapped && c > 0 && c % 2 == 0) begin
                    pre_hs = 1'b1; pre_clken = 1'b0;
                    @(negedge clk);
                end
                if (r == rst_row && c == rst_col) begin
                    mid_reset();
                    return;
                end
                pre_hs      = !(c == cols - 1 && r % 2 == 1);
                pre_clken   = 1'b1;
                pre_imgbit  = img[r][c];
                pre_imgdata = dat[r][c];
                if (exp_mode == 2'b01 || exp_mode == 2'b10) begin
                    v   = gold(r, c, exp_mode);
                    e.b = v;
                    e.d = {16{v}};
                end else begin
                    e.b = img[r][c];
                    e.d = dat[r][c];
                end
                e.cyc = cyc;
                sb.push_back(e);
                @(negedge clk);
            end
            pre_hs = 1'b0; pre_clken = 1'b0; pre_imgbit = 1'b0;
            repeat (2) @(negedge clk);
        end
        pre_vs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Scoreboard consumer: every qualified output pops one expected pixel
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && post_clken) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pix_bit",  post_imgbit,  e.b);
                check("pix_data", post_imgdata, e.d);
                check("latency",  cyc - e.cyc,  3);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pre_vs = 0; pre_hs = 0; pre_clken = 0; pre_imgbit = 0; pre_imgdata = '0;
        cfg_mode = 2'b00;
        exp_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_vs",    post_vs,      0);
        check("rst_hs",    post_hs,      0);
        check("rst_clken", post_clken,   0);
        check("rst_bit",   post_imgbit,  0);
        check("rst_data",  post_imgdata, 0);
        check("rst_mode",  frame_mode,   0);
        check("rst_ovf",   line_ovf,     0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_img(0);
        run_frame(2'b00, 8, 8, 1'b0, -1, 2'b00, -1, -1);
        check("mode_bypass", frame_mode, 2'b00);

        fill_img(1);
        run_frame(2'b01, 8, 8, 1'b0, -1, 2'b00, -1, -1);
        check("mode_erode", frame_mode, 2'b01);

        fill_img(2);
        run_frame(2'b10, 8, 8, 1'b0, -1, 2'b00, -1, -1);
        check("mode_dilate", frame_mode, 2'b10);

        fill_img(3);
        run_frame(2'b01, 8, 8, 1'b0, 3, 2'b10, -1, -1);
        check("mode_midchg", frame_mode, 2'b01);

        fill_img(0);
        run_frame(2'b10, 8, 8, 1'b1, -1, 2'b00, -1, -1);
        check("mode_next", frame_mode, 2'b10);

        fill_img(0);
        run_frame(2'b00, 3, 10, 1'b1, -1, 2'b00, -1, -1);
        check("ovf_set", line_ovf, 1);

        fill_img(0);
        run_frame(2'b11, 8, 8, 1'b0, -1, 2'b00, -1, -1);
        check("ovf_clear", line_ovf, 0);
        check("mode_rsvd", frame_mode, 2'b11);

        fill_img(3);
        run_frame(2'b01, 8, 8, 1'b0, -1, 2'b00, 5, 3);
        check("mode_after_rst", frame_mode, 2'b00);

        fill_img(3);
        run_frame(2'b01, 8, 8, 1'b1, -1, 2'b00, -1, -1);
        check("mode_post_rst", frame_mode, 2'b01);

        repeat (5) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
